fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of the asynchronous FIFO among N_REQ requesters in the write-clock domain. Owns a requester for a bounded burst, forwards its data and push to the FIFO write side, and stalls it on full. Sits directly in front of the FIFO write-pointer logic; its w_push/w_data drive the FIFO write port and its w_full input comes from the FIFO full flag.

---
 rtl/fifo_wr_arbiter_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 44 ++++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and constants for the FIFO write-port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, OWN)
//   - id_width()  : width of a requester index, never less than 1
//   - DEF_*       : default parameter values for the arbiter
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotating find-first. Scans req starting at rr_ptr and
//   walking upward, wrapping from N_REQ-1 back to 0; reports the first set
//   bit found.
//   Ports:
//     req    in  N_REQ  request vector
//     rr_ptr in  ID_W   index with highest priority this scan
//     valid  out 1      at least one request set
//     index  out ID_W   winning requester index (0 when !valid)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = id_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  index
);

    always_comb begin
        int             pos;
        logic [ID_W-1:0] cand;
        valid = 1'b0;
        index = '0;
        pos   = 0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            cand = ID_W'(pos);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of the asynchronous
//   FIFO among N_REQ write-domain requesters. One owner at a time is granted
//   for up to MAX_BURST words; its data and push are forwarded to the FIFO
//   and it is stalled while the FIFO reports full.
//   Ports:
//     w_clk     in  1                 write-domain clock
//     w_rst_n   in  1                 asynchronous active-low reset
//     req       in  N_REQ             per-requester valid, held until acked
//     req_data  in  N_REQ*DATA_WIDTH  packed requester data
//     ack       out N_REQ             one-hot word-accepted strobe
//     grant_id  out $clog2(N_REQ)     current owner index
//     busy      out 1                 high while an owner holds the port
//     w_push    out 1                 FIFO write strobe (already full-gated)
//     w_data    out DATA_WIDTH        FIFO write data
//     w_full    in  1                 FIFO full flag
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                        w_clk,
    input  logic                        w_rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy,
    output logic                        w_push,
    output logic [DATA_WIDTH-1:0]       w_data,
    input  logic                        w_full
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    arb_state_t      state;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] rr_ptr;
    logic [CNT_W-1:0] burst_cnt;

    logic [DATA_WIDTH-1:0] data_arr [N_REQ];
    logic                  own;
    logic                  owner_req;
    logic                  push;
    logic                  rel;
    logic [ID_W-1:0]       next_ptr;
    logic [ID_W-1:0]       pick_ptr;
    logic                  pick_valid;
    logic [ID_W-1:0]       pick_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign own       = (state == OWN);
    assign owner_req = req[owner];
    assign push      = own && owner_req && !w_full;
    // Release on the last word of a burst, or as soon as the owner withdraws.
    assign rel       = own && ((push && (burst_cnt == LAST_CNT)) || !owner_req);
    assign next_ptr  = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    // In OWN the picker already looks from owner+1, so a handoff needs no
    // extra cycle and the current owner naturally ranks last.
    assign pick_ptr  = own ? next_ptr : rr_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (pick_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    always_comb begin
        ack        = '0;
        ack[owner] = push;
    end

    assign w_push   = push;
    assign w_data   = own ? data_arr[owner] : '0;
    assign grant_id = owner;
    assign busy     = own;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (rel) begin
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                        if (pick_valid) begin
                            owner <= pick_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (push) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : fifo_wr_arbiter
